// File: rtl/tt_add_arb_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package tt_add_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    localparam int ARB_NREQ_MIN = 2;
    localparam int ARB_NREQ_MAX = 8;

endpackage

// File: rtl/tt_add_arbiter_if.sv
// Requester and response handshake bundle for tt_add_arbiter.
interface tt_add_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [W-1:0]           rsp_data;
    logic                   rsp_carry;
    logic [IDW-1:0]         rsp_id;

    // The requesters plus the response consumer form the master side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );
endinterface

// File: rtl/tt_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_i, wrapping.
module tt_rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int cand;
        cand    = 0;
        idx_o   = '0;
        any_o   = 1'b0;
        // Offset NREQ wraps back to last_i itself, so it is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_i) + k) % NREQ;
            if (!any_o && req_i[IDW'(cand)]) begin
                any_o = 1'b1;
                idx_o = IDW'(cand);
            end
        end
        grant_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/tt_add_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among NREQ requesters.
// Define TT_ADD_ARB_SATURATE_EN to saturate rsp_data on overflow instead of wrapping.
module tt_add_arbiter
    import tt_add_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input logic             clk,
    input logic             rst,
    tt_add_arbiter_if.slave bus
);

    arb_state_e     state_q;
    logic [IDW-1:0] last_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_carry_q;
    logic [IDW-1:0] rsp_id_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic            accept;
    logic [W:0]      sum;
    logic [W-1:0]    rsp_data_d;

    tt_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // A held result being taken this cycle frees the register for a refill.
    assign can_accept    = (state_q == ST_EMPTY) || bus.rsp_ready;
    assign accept        = can_accept && grant_any;
    assign bus.req_ready = accept ? grant : '0;

    assign sum = {1'b0, bus.req_a[grant_idx]} + {1'b0, bus.req_b[grant_idx]};

`ifdef TT_ADD_ARB_SATURATE_EN
    assign rsp_data_d = sum[W] ? '1 : sum[W-1:0];
`else
    assign rsp_data_d = sum[W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            last_q      <= IDW'(NREQ - 1);
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
        end else if (accept) begin
            state_q     <= ST_FULL;
            last_q      <= grant_idx;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= sum[W];
            rsp_id_q    <= grant_idx;
        end else if (state_q == ST_FULL && bus.rsp_ready) begin
            state_q     <= ST_EMPTY;
        end
    end

    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: doc/tt_add_arbiter.md
# tt_add_arbiter

Round-robin arbiter and sequencer that shares a single W-bit adder (the `uo_out = ui_in + uio_in` datapath) between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the sum with carry and requester ID, and holds it in a one-entry response register until the consumer takes it. It sits between the pin-level input muxing and the output driver of the tile.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand and result width.
- `IDW`, default `$clog2(NREQ)`: requester ID width. Derived; do not override.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input [NREQ]: requester i has an operand pair.
- `req_ready` output [NREQ]: one-hot or zero; requester i accepted this cycle.
- `req_a` input [NREQ][W]: operand A per requester.
- `req_b` input [NREQ][W]: operand B per requester.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output [W]: sum, wrapped or saturated (see Configuration).
- `rsp_carry` output 1: carry-out of the full W+1-bit sum.
- `rsp_id` output [IDW]: index of the requester that produced the result.

## Operation
- FSM has two states. EMPTY: no result held. FULL: result held, `rsp_valid`=1.
- `can_accept` = EMPTY, or (FULL and `rsp_ready`). FULL with `rsp_ready` is a simultaneous drain and refill.
- Grant: pick the first asserted `req_valid` scanning from `last+1` upward and wrapping modulo NREQ. `req_ready[g]` = `can_accept` and grant g. All other `req_ready` bits are 0.
- On accept, at the next edge:
  - `rsp_data`/`rsp_carry` ← `req_a[g] + req_b[g]`, computed at W+1 bits.
  - `rsp_id` ← g.
  - `last` ← g.
  - state ← FULL.
- On FULL with `rsp_ready` and no accept: state ← EMPTY. Data registers keep their old values.
- `last` updates only on accept. A requester that deasserts valid does not move the pointer.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Once a requester asserts `req_valid`, it holds valid and its operands stable until `req_ready`. This is a requester obligation; the block does not check it.
- Starvation bound: a requester held valid is granted within NREQ accepts.

## Timing
- Reset values: state EMPTY, `rsp_valid`=0, `rsp_data`=0, `rsp_carry`=0, `rsp_id`=0, all `req_ready`=0. `last`=NREQ-1, so requester 0 has top priority after reset.
- Latency: accept at edge N gives `rsp_valid`=1 after edge N.
- Throughput: 1 result per cycle while `rsp_ready` is held at 1.
- Backpressure: with `rsp_ready`=0 in FULL, all `req_ready`=0. Response outputs stay stable until taken.
- Reset asserted mid-operation: any held result is discarded immediately and asynchronously. Any in-flight grant is lost, and the requester must re-present.

## Configuration
- `TT_ADD_ARB_SATURATE_EN` defined: if the W+1-bit sum is ≥ 2^W, `rsp_data` = all ones. `rsp_carry` still reports 1.
- Not defined: `rsp_data` = sum modulo 2^W (wrap), and `rsp_carry` = bit W.

## Structure
- Package `tt_add_arb_pkg`: the state enum (`ST_EMPTY`, `ST_FULL`) and the `NREQ` bound constants `ARB_NREQ_MIN`=2 and `ARB_NREQ_MAX`=8.
- Sub-module `tt_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last`. Outputs are the one-hot grant, the encoded index, and `any`. The top module holds the FSM, the pointer, the adder and the response register.

## Test plan
- Reset, then `req_valid`=0001, a=0x12, b=0x34, `rsp_ready`=1 → `req_ready`=0001. The next cycle shows `rsp_valid`=1, data 0x46, carry 0, id 0.
- All four valid every cycle, `rsp_ready`=1 → grant order 0,1,2,3,0,…, one result per cycle.
- `rsp_ready`=0 while FULL with req 2 valid → `req_ready`=0 and the response holds for 5 cycles. Raising `rsp_ready` drains the response and accepts req 2 in the same cycle.
- Req 1: a=0xF0, b=0x20 → carry 1, with data 0x10 (wrap) or 0xFF (`TT_ADD_ARB_SATURATE_EN`).
- Assert `rst` mid-stream while FULL → `rsp_valid` drops at once. After release, req 0 wins over req 3 when both are valid.
- Only req 3 valid repeatedly, then req 0 and req 3 both valid → req 0 is granted first, since `last`=3.
